// File: rtl/posit_regime_decode.sv
// posit_regime_decode: second stage of the posit-to-float path.
// Takes a posit word and the regime run length found by the leading-one
// detector. Produces sign, combined scale (k*2^ES + e) and an MSB-aligned
// fraction through a two-stage valid/ready pipeline. There is no skid buffer:
// in_ready is combinational from out_ready.
// Optional build macro POSIT_DEC_STATS_EN adds saturating transfer counters
// (stat_words, stat_nar).
module posit_regime_decode #(
  parameter int N  = 32,
  parameter int ES = 2,
  localparam int S  = $clog2(N),
  localparam int SW = S + ES + 1,
  localparam int F  = N - 3 - ES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  input  logic [S-1:0]  in_run,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [SW-1:0] out_scale,
  output logic [F-1:0]  out_frac,
  output logic          out_zero,
  output logic          out_nar
`ifdef POSIT_DEC_STATS_EN
  ,
  output logic [15:0]   stat_words,
  output logic [15:0]   stat_nar
`endif
);

  localparam int STAGES = 2;
  localparam logic [S:0] ONE = (S+1)'(1);

  // Stage 1 keeps only rem[N-2:2]. The regime always consumes at least
  // one bit and its terminator, so the two lowest rem bits never reach
  // e or frac. That leaves exactly {e, frac}: ES + F = N-3 bits.
  typedef struct packed {
    logic           sign;
    logic           zero;
    logic           nar;
    logic [S:0]     k;
    logic [N-4:0]   rem;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic           zero;
    logic           nar;
    logic [SW-1:0]  scale;
    logic [F-1:0]   frac;
  } s2_t;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_t             s1_q, s1_d, s1_new;
  s2_t             s2_q, s2_d, s2_new;
  logic            adv1, adv2;

  logic [N-2:0]    body;
  logic [S:0]      run_ext;
  logic [S:0]      sh;
  logic            special;

  // Handshake: a stage may load when it is empty or its successor advances.
  always_comb begin
    adv2     = ~vld_pipe_q[2] | out_ready;
    adv1     = ~vld_pipe_q[1] | adv2;
    in_ready = adv1;
  end

  // Stage-1 decode: take the magnitude, then strip the regime and its terminator.
  always_comb begin
    // Only the low N-1 bits of -posit matter, and they depend only on
    // the low N-1 bits of posit.
    body    = in_posit[N-1] ? (N-1)'(-in_posit[N-2:0]) : in_posit[N-2:0];
    run_ext = {1'b0, in_run};
    sh      = run_ext + ONE;
    s1_new.sign = in_posit[N-1];
    s1_new.zero = ~in_posit[N-1] & (in_posit[N-2:0] == '0);
    s1_new.nar  =  in_posit[N-1] & (in_posit[N-2:0] == '0);
    s1_new.k    = body[N-2] ? (run_ext - ONE) : (-run_ext);
    // Shifting by N-1 or more clears the field, so a regime that fills
    // the whole body gives e = 0 and frac = 0.
    s1_new.rem  = (N-3)'((body << sh) >> 2);
  end

  // Stage-2 decode: scale = (k << ES) + e. Because e < 2^ES, this is just
  // {k, e}. Zero and NaR force the numeric fields to 0.
  always_comb begin
    special       = s1_q.zero | s1_q.nar;
    s2_new.sign   = s1_q.sign;
    s2_new.zero   = s1_q.zero;
    s2_new.nar    = s1_q.nar;
    s2_new.scale  = special ? '0 : {s1_q.k, s1_q.rem[N-4 -: ES]};
    s2_new.frac   = special ? '0 : s1_q.rem[F-1:0];
  end

  // Next state: an advancing stage loads new data; a stalled stage holds.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (adv1) begin
      vld_pipe_d[1] = in_valid;
      if (in_valid) s1_d = s1_new;
    end
    if (adv2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) s2_d = s2_new;
    end
  end

  // Pipeline registers. Reset drops any in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_sign  = s2_q.sign;
  assign out_scale = s2_q.scale;
  assign out_frac  = s2_q.frac;
  assign out_zero  = s2_q.zero;
  assign out_nar   = s2_q.nar;

`ifdef POSIT_DEC_STATS_EN
  logic        out_fire;
  logic [15:0] stat_words_q, stat_words_d;
  logic [15:0] stat_nar_q, stat_nar_d;

  // Saturating counters that advance on output transfers.
  always_comb begin
    out_fire     = vld_pipe_q[2] & out_ready;
    stat_words_d = stat_words_q;
    stat_nar_d   = stat_nar_q;
    if (out_fire) begin
      if (stat_words_q != 16'hFFFF) stat_words_d = stat_words_q + 16'd1;
      if (s2_q.nar && (stat_nar_q != 16'hFFFF)) stat_nar_d = stat_nar_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_nar_q   <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_nar_q   <= stat_nar_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_nar   = stat_nar_q;
`endif

endmodule

// File: tb/tb_posit_regime_decode.sv
// Directed bench for posit_regime_decode (N=32, ES=2).
module tb_posit_regime_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_posit;
  logic [4:0]  in_run;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_scale;
  logic [26:0] out_frac;
  logic        out_zero;
  logic        out_nar;
`ifdef POSIT_DEC_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_nar;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  posit_regime_decode #(.N(32), .ES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .in_run    (in_run),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_scale (out_scale),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_nar   (out_nar)
`ifdef POSIT_DEC_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_nar  (stat_nar)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push one word through an otherwise empty pipe and check latency and fields.
  task automatic one(input string tag, input logic [31:0] p, input logic [4:0] r,
                     input logic s, input logic [7:0] sc, input logic [26:0] fr,
                     input logic z, input logic nr);
    @(negedge clk);
    in_valid = 1'b1; in_posit = p; in_run = r; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sign"},  32'(out_sign),  32'(s));
    chk({tag, "_scale"}, 32'(out_scale), 32'(sc));
    chk({tag, "_frac"},  32'(out_frac),  32'(fr));
    chk({tag, "_zero"},  32'(out_zero),  32'(z));
    chk({tag, "_nar"},   32'(out_nar),   32'(nr));
  endtask

  logic [31:0] words [5];
  logic [7:0]  scales[5];
  logic [7:0]  prev_scale;
  logic        prev_stall;

  initial begin
    int in_idx, out_idx;
    words[0] = 32'h40000000; scales[0] = 8'd0;
    words[1] = 32'h48000000; scales[1] = 8'd1;
    words[2] = 32'h50000000; scales[2] = 8'd2;
    words[3] = 32'h58000000; scales[3] = 8'd3;
    words[4] = 32'h60000000; scales[4] = 8'd4;

    rst_n = 1'b0; in_valid = 1'b0; in_posit = '0; in_run = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_scale",     32'(out_scale), 32'd0);
    chk("rst_frac",      32'(out_frac),  32'd0);
    chk("rst_flags",     32'({out_sign, out_zero, out_nar}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    one("t1_one",   32'h40000000, 5'd1,  1'b0, 8'd0,           27'd0,         1'b0, 1'b0);
    one("t2_pos",   32'h48000000, 5'd1,  1'b0, 8'd1,           27'd0,         1'b0, 1'b0);
    one("t2_neg",   32'h20000000, 5'd1,  1'b0, 8'hFC,          27'd0,         1'b0, 1'b0);
    one("t3_sign",  32'hC0000000, 5'd1,  1'b1, 8'd0,           27'd0,         1'b0, 1'b0);
    one("t3_max",   32'h7FFFFFFF, 5'd31, 1'b0, 8'd120,         27'd0,         1'b0, 1'b0);
    one("t3_min",   32'h00000001, 5'd30, 1'b0, 8'h88,          27'd0,         1'b0, 1'b0);
    one("t4_zero",  32'h00000000, 5'd31, 1'b0, 8'd0,           27'd0,         1'b1, 1'b0);
    one("t4_nar",   32'h80000000, 5'd31, 1'b1, 8'd0,           27'd0,         1'b0, 1'b1);
    one("frac_pos", 32'h4C000000, 5'd1,  1'b0, 8'd1,           27'h4000000,   1'b0, 1'b0);
    one("frac_neg", 32'hB4000000, 5'd1,  1'b1, 8'd1,           27'h4000000,   1'b0, 1'b0);
    one("run4",     32'h7A000000, 5'd4,  1'b0, 8'd14,          27'd0,         1'b0, 1'b0);

    // Back-to-back stream with the consumer stalled for the first 3 cycles.
    in_idx = 0; out_idx = 0; prev_stall = 1'b0; prev_scale = '0;
    for (int cyc = 0; cyc < 40 && out_idx < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (in_idx < 5);
      in_posit  = (in_idx < 5) ? words[in_idx] : 32'd0;
      in_run    = (in_idx == 4) ? 5'd2 : 5'd1;
      #1;
      if (cyc == 2) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepted", 32'(in_idx),   32'd2);
      end
      if (prev_stall) chk("stall_stable", 32'(out_scale), 32'(prev_scale));
      prev_stall = out_valid & ~out_ready;
      prev_scale = out_scale;
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        chk("stream_scale", 32'(out_scale), 32'(scales[out_idx]));
        out_idx++;
      end
    end
    chk("stream_count", 32'(out_idx), 32'd5);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("stream_no_dup", 32'(out_valid), 32'd0);

    // Reset with the pipe full and stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_posit = 32'h48000000; in_run = 5'd1;
    repeat (3) @(negedge clk);
    chk("pre_rst_full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_scale", 32'(out_scale), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
